// File: rtl/mac_operand_sequencer_if.sv
// Operand stream into the sequencer and operand/handshake lines out to the shift-add MAC stage.
interface mac_operand_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              MAC_START;
  logic              mac_done;

  // Environment side: offers operand pairs and plays the MAC stage.
  modport master (
    output in_valid, in_a, in_b, mac_done,
    input  in_ready, A, B, MAC_START
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, mac_done,
    output in_ready, A, B, MAC_START
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Buffers A/B operand pairs and issues them one at a time to the shift-add MAC stage, counting pairs per frame.
// Optional WAIT watchdog enabled by defining MAC_SEQ_TIMEOUT_EN.
module mac_operand_sequencer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_operand_sequencer_if.slave bus,
  input  logic [CNT_W-1:0]       frame_len,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       op_count,
  output logic                   timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  logic [CNT_W-1:0]  frame_len_q;
  logic              last_pair;
  logic              abort_q;
  logic              tmo_hit;

  // A frame_len of zero behaves as a one-pair frame.
  function automatic logic [CNT_W-1:0] eff_frame_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign pop          = (state == S_IDLE) && !fifo_empty;
  assign busy         = (state != S_IDLE) || !fifo_empty;
  assign last_pair    = ((op_count + CNT_W'(1)) == eff_frame_len(frame_len_q));

  // ---- operand FIFO: pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  // ---- operand hold registers: change only on pop, stable ISSUE..RELEASE
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.A <= '0;
      bus.B <= '0;
    end else if (pop) begin
      bus.A <= mem_a[rd_ptr];
      bus.B <= mem_b[rd_ptr];
    end
  end

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Fires in the TIMEOUT-th WAIT cycle if the MAC stage still has not answered.
  assign tmo_hit = (state == S_WAIT) && !bus.mac_done && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT;
  assign tmo_hit            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // ---- sequencer FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.MAC_START = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // mac_done may still be high from the previous pair; not looked at here.
        bus.MAC_START = 1'b1;
        state_nxt     = S_ARM;
      end
      S_ARM: begin
        bus.MAC_START = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        bus.MAC_START = 1'b1;
        if (bus.mac_done || tmo_hit) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- frame accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count    <= '0;
      frame_len_q <= '0;
      frame_done  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if ((state == S_ISSUE) && (op_count == '0)) begin
        frame_len_q <= frame_len;
      end
      if (state == S_WAIT) begin
        abort_q <= tmo_hit;
      end
      // An aborted pair neither counts nor closes a frame.
      if ((state == S_RELEASE) && !abort_q) begin
        if (last_pair) begin
          op_count   <= '0;
          frame_done <= 1'b1;
        end else begin
          op_count   <= op_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed scoreboard bench for mac_operand_sequencer with a behavioural shift-add MAC stage model.
module tb_mac_operand_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  frame_len;
  logic        busy;
  logic        frame_done;
  logic [7:0]  op_count;
  logic        timeout_err;

  mac_operand_sequencer_if #(.DATA_W(16)) bus ();

  mac_operand_sequencer #(
    .DATA_W (16),
    .DEPTH  (4),
    .CNT_W  (8),
    .TIMEOUT(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_len  (frame_len),
    .busy       (busy),
    .frame_done (frame_done),
    .op_count   (op_count),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] sb[$];
  logic [7:0]  oc_log[$];
  int          fd_at[$];
  int          issue_cnt = 0;
  int          rel_cnt   = 0;
  int          fd_cnt    = 0;

  // MAC stage model: latches start, answers after ~17 cycles, accumulates A*B.
  logic        mac_hold;
  logic        acc_clr;
  logic        mac_latched;
  logic        mac_busy;
  int          mac_cnt;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [39:0] mac_acc;

  always @(posedge clk) begin
    if (reset) begin
      mac_latched  <= 1'b0;
      mac_busy     <= 1'b0;
      mac_cnt      <= 0;
      bus.mac_done <= 1'b0;
    end else if (!bus.MAC_START) begin
      mac_latched <= 1'b0;
      mac_busy    <= 1'b0;
    end else if (!mac_latched) begin
      mac_latched  <= 1'b1;
      mac_busy     <= 1'b1;
      mac_cnt      <= 0;
      mac_a        <= bus.A;
      mac_b        <= bus.B;
      bus.mac_done <= 1'b0;
    end else if (mac_busy) begin
      if (mac_cnt >= 15 && !mac_hold) begin
        mac_busy     <= 1'b0;
        bus.mac_done <= 1'b1;
        mac_acc      <= mac_acc + 40'(mac_a) * 40'(mac_b);
      end else if (mac_cnt < 15) begin
        mac_cnt <= mac_cnt + 1;
      end
    end
    if (acc_clr) mac_acc <= '0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("push_accept", 64'(t < 100), 1);
    sb.push_back({a, b});
    @(negedge clk);
  endtask

  task automatic drop_valid();
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 600) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(t < 600), 1);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard/monitor: checks issued operands, their stability and frame_done shape.
  initial begin
    logic        prev_start;
    logic        prev_fd;
    logic [15:0] prev_a;
    logic [15:0] prev_b;
    logic [31:0] e;
    prev_start = 1'b0;
    prev_fd    = 1'b0;
    prev_a     = '0;
    prev_b     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_start = 1'b0;
        prev_fd    = 1'b0;
      end else begin
        if (bus.MAC_START && !prev_start) begin
          issue_cnt++;
          oc_log.push_back(op_count);
          check("sb_has_entry", 64'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("issue_A", bus.A, e[31:16]);
            check("issue_B", bus.B, e[15:0]);
          end
        end else if (bus.MAC_START) begin
          check("hold_A", bus.A, prev_a);
          check("hold_B", bus.B, prev_b);
        end
        if (!bus.MAC_START && prev_start) rel_cnt++;
        if (frame_done) begin
          fd_cnt++;
          fd_at.push_back(rel_cnt);
          check("fd_one_cycle", prev_fd, 0);
        end
        prev_start = bus.MAC_START;
        prev_fd    = frame_done;
        prev_a     = bus.A;
        prev_b     = bus.B;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          base_fd;
    int          base_rel;
    int          base_iss;
    int          n;
    logic [39:0] exp_acc;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    frame_len    = 8'd1;
    mac_hold     = 1'b0;
    acc_clr      = 1'b1;
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    acc_clr = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_MAC_START", bus.MAC_START, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_A", bus.A, 0);
    check("rst_B", bus.B, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Single pair, frame_len=1
    clear_acc();
    base_fd  = fd_cnt;
    base_rel = rel_cnt;
    frame_len = 8'd1;
    push(16'd3, 16'd5);
    drop_valid();
    wait_idle("t2_idle");
    check("t2_acc", mac_acc, 15);
    check("t2_frame_done_cnt", 64'(fd_cnt - base_fd), 1);
    check("t2_release_cnt", 64'(rel_cnt - base_rel), 1);
    check("t2_op_count", op_count, 0);
    check("t2_MAC_START", bus.MAC_START, 0);

    // Frame of four
    clear_acc();
    base_fd  = fd_cnt;
    base_rel = rel_cnt;
    fd_at.delete();
    oc_log.delete();
    frame_len = 8'd4;
    push(16'd1, 16'd2);
    push(16'd3, 16'd4);
    push(16'd5, 16'd6);
    push(16'd7, 16'd8);
    drop_valid();
    wait_idle("t3_idle");
    check("t3_acc", mac_acc, 100);
    check("t3_frame_done_cnt", 64'(fd_cnt - base_fd), 1);
    check("t3_fd_log_size", 64'(fd_at.size()), 1);
    if (fd_at.size() == 1) check("t3_fd_after_pair", 64'(fd_at[0] - base_rel), 4);
    check("t3_oc_log_size", 64'(oc_log.size()), 4);
    for (int i = 0; i < oc_log.size() && i < 4; i++) check("t3_op_count_step", oc_log[i], 64'(i));
    check("t3_op_count_end", op_count, 0);

    // Back-pressure, frame_len=0 behaves as 1
    clear_acc();
    base_fd  = fd_cnt;
    base_rel = rel_cnt;
    frame_len = 8'd0;
    exp_acc   = '0;
    for (int i = 0; i < 6; i++) begin
      push(16'(100 + i), 16'(2 * i + 1));
      exp_acc = exp_acc + 40'(100 + i) * 40'(2 * i + 1);
      if (i == 3) check("t4_in_ready_after4", bus.in_ready, 1);
      if (i == 4) check("t4_in_ready_after5", bus.in_ready, 0);
    end
    drop_valid();
    wait_idle("t4_idle");
    check("t4_acc", mac_acc, exp_acc);
    check("t4_frame_done_cnt", 64'(fd_cnt - base_fd), 6);
    check("t4_release_cnt", 64'(rel_cnt - base_rel), 6);
    check("t4_sb_empty", 64'(sb.size()), 0);
    check("t4_op_count", op_count, 0);

    // Reset during WAIT of the second pair
    frame_len = 8'd4;
    base_iss  = issue_cnt;
    push(16'd20, 16'd1);
    push(16'd21, 16'd2);
    push(16'd22, 16'd3);
    drop_valid();
    n = 0;
    while (issue_cnt < base_iss + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_second_issue", 64'(n < 200), 1);
    repeat (5) @(negedge clk);
    check("t5_pre_MAC_START", bus.MAC_START, 1);
    check("t5_pre_op_count", op_count, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_MAC_START", bus.MAC_START, 0);
    check("t5_busy", busy, 0);
    check("t5_op_count", op_count, 0);
    check("t5_in_ready", bus.in_ready, 1);
    check("t5_A", bus.A, 0);
    reset = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    check("t5_stays_idle", busy, 0);

    // WAIT timeout behaviour
    frame_len = 8'd4;
    mac_hold  = 1'b1;
    base_fd   = fd_cnt;
    base_rel  = rel_cnt;
    push(16'd40, 16'd2);
    push(16'd41, 16'd3);
    drop_valid();
    n = 0;
    while (!bus.MAC_START && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_issue_seen", 64'(n < 50), 1);
`ifdef MAC_SEQ_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t6_timeout_cycle", 64'(n), 34);
    check("t6_release_low", bus.MAC_START, 0);
    check("t6_op_count_abort", op_count, 0);
    mac_hold = 1'b0;
    wait_idle("t6_idle");
    check("t6_op_count_next", op_count, 1);
    check("t6_timeout_sticky", timeout_err, 1);
    check("t6_no_frame_done", 64'(fd_cnt - base_fd), 0);
    check("t6_release_cnt", 64'(rel_cnt - base_rel), 2);
    check("t6_sb_empty", 64'(sb.size()), 0);
`else
    repeat (60) @(negedge clk);
    check("t6_wait_held", bus.MAC_START, 1);
    check("t6_no_timeout", timeout_err, 0);
    check("t6_busy", busy, 1);
    check("t6_op_count_hold", op_count, 0);
    mac_hold = 1'b0;
    wait_idle("t6_idle");
    check("t6_op_count_next", op_count, 2);
    check("t6_no_timeout_end", timeout_err, 0);
    check("t6_no_frame_done", 64'(fd_cnt - base_fd), 0);
    check("t6_release_cnt", 64'(rel_cnt - base_rel), 2);
    check("t6_sb_empty", 64'(sb.size()), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
